dist_sensor: RTL

Ultrasonic ranging front end that produces the `dist_v` distance word consumed by the `robot` controller. It periodically fires a trigger pulse and times the returned echo pulse. It converts the echo width to centimetres with a cycle prescaler and presents the result as a held 16-bit value plus a one-cycle update strobe. It sits between the sensor pins and `robot.dist_v`, on the same `clk`/`rstn` domain.

---
 rtl/robot_pkg.sv | 18 +
 rtl/dist_avg4.sv | 51 +++++
 rtl/dist_sensor.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/robot_pkg.sv
// Shared types and constants for the robot ranging path.
// Contents: dist_state_t (ranging FSM states), DIST_W (distance word width),
// DIST_NONE (distance code for no target / timeout).
package robot_pkg;

   localparam int unsigned DIST_W = 16;

   localparam logic [DIST_W-1:0] DIST_NONE = 16'hFFFF;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      DONE
   } dist_state_t;

endpackage

// File: rtl/dist_avg4.sv
// Four-sample moving average of valid distance results.
// Ports:
//   clk, rstn : clock and synchronous active-low reset (history flushed to empty)
//   push      : a new valid sample is accepted this cycle
//   sample    : the new sample
//   avg       : average including 'sample' as if it were pushed now, so the
//               caller can register it in the same cycle as the push
// Sum is 18 bits wide; division is a shift by 0/1/2 for 1/2/3+ samples, so
// three samples are divided by 4.
module dist_avg4
   import robot_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              push,
   input  logic [DIST_W-1:0] sample,
   output logic [DIST_W-1:0] avg
);

   // Only the three most recent older samples are stored; the fourth is 'sample'.
   logic [DIST_W-1:0] h0, h1, h2;
   logic [1:0]        n;  // number of stored samples, 0..3
   logic [17:0]       sum;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         h0 <= '0;
         h1 <= '0;
         h2 <= '0;
         n  <= 2'd0;
      end else if (push) begin
         h2 <= h1;
         h1 <= h0;
         h0 <= sample;
         if (n != 2'd3) n <= n + 2'd1;
      end
   end

   always_comb begin
      sum = {2'b00, sample};
      if (n > 2'd0) sum = sum + {2'b00, h0};
      if (n > 2'd1) sum = sum + {2'b00, h1};
      if (n > 2'd2) sum = sum + {2'b00, h2};
      case (n)
         2'd0:    avg = sum[15:0];
         2'd1:    avg = sum[16:1];
         default: avg = sum[17:2];
      endcase
   end

endmodule

// File: rtl/dist_sensor.sv
// Ultrasonic ranging front end: fires a periodic trigger pulse, times the
// returned echo and publishes the distance in centimetres.
// Ports:
//   clk, rstn : system clock, synchronous active-low reset
//   echo      : asynchronous echo pin (2-flop synchronized internally)
//   trig      : trigger pin to the sensor
//   dist_v    : last distance in cm, 16'hFFFF = no target / timeout
//   dist_upd  : one-cycle strobe in the cycle dist_v is written
//   timeout   : set with a timeout write, cleared by the next valid write
// Build option: define DIST_AVG_EN to publish a 4-sample moving average of
// valid results instead of the raw per-measurement value.
module dist_sensor
   import robot_pkg::*;
#(
   parameter int unsigned TRIG_CYCLES    = 1000,
   parameter int unsigned CYCLES_PER_CM  = 5800,
   parameter int unsigned TIMEOUT_CYCLES = 2500000,
   parameter int unsigned PERIOD_CYCLES  = 6000000
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              echo,
   output logic              trig,
   output logic [DIST_W-1:0] dist_v,
   output logic              dist_upd,
   output logic              timeout
);

   localparam logic [DIST_W-1:0] CmMax = 16'hFFFE;

   dist_state_t       state;
   logic              echo_m, echo_s;
   logic [31:0]       per_cnt;  // free-running trigger period counter
   logic [31:0]       cnt;      // trigger width, then timeout / echo-high count
   logic [31:0]       pre;      // cycles within the current centimetre
   logic [DIST_W-1:0] cm;
   logic [DIST_W-1:0] valid_val;

`ifdef DIST_AVG_EN
   logic meas_done;

   assign meas_done = (state == MEASURE) && !echo_s;

   dist_avg4 u_avg (
      .clk    (clk),
      .rstn   (rstn),
      .push   (meas_done),
      .sample (cm),
      .avg    (valid_val)
   );
`else
   assign valid_val = cm;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         echo_m   <= 1'b0;
         echo_s   <= 1'b0;
         state    <= IDLE;
         per_cnt  <= '0;
         cnt      <= '0;
         pre      <= '0;
         cm       <= '0;
         trig     <= 1'b0;
         dist_v   <= '0;
         dist_upd <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         echo_m   <= echo;
         echo_s   <= echo_m;
         dist_upd <= 1'b0;
         per_cnt  <= (per_cnt == PERIOD_CYCLES - 1) ? '0 : per_cnt + 32'd1;

         // Results are written on the transition into DONE so the strobe is
         // high during DONE, one cycle after the FSM sees the echo fall.
         case (state)
            IDLE: begin
               if (per_cnt == PERIOD_CYCLES - 1) begin
                  state <= TRIG;
                  trig  <= 1'b1;
                  cnt   <= '0;
               end
            end
            TRIG: begin
               if (cnt == TRIG_CYCLES - 1) begin
                  state <= WAIT_RISE;
                  trig  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            WAIT_RISE: begin
               if (echo_s) begin
                  // The rise cycle is the first echo-high cycle measured.
                  state <= MEASURE;
                  cnt   <= 32'd1;
                  pre   <= 32'd1;
                  cm    <= '0;
               end else if (cnt == TIMEOUT_CYCLES - 1) begin
                  state    <= DONE;
                  dist_v   <= DIST_NONE;
                  dist_upd <= 1'b1;
                  timeout  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            MEASURE: begin
               if (!echo_s) begin
                  state    <= DONE;
                  dist_v   <= valid_val;
                  dist_upd <= 1'b1;
                  timeout  <= 1'b0;
               end else if (cnt == TIMEOUT_CYCLES - 1) begin
                  state    <= DONE;
                  dist_v   <= DIST_NONE;
                  dist_upd <= 1'b1;
                  timeout  <= 1'b1;
               end else begin
                  cnt <= cnt + 32'd1;
                  if (pre == CYCLES_PER_CM - 1) begin
                     pre <= '0;
                     if (cm != CmMax) cm <= cm + 16'd1;
                  end else begin
                     pre <= pre + 32'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
